// File: rtl/fp_norm_round.sv
// fp_norm_round: two-stage normalize / round-to-nearest-even / pack to IEEE-754 single.
// Optional FP_NR_FLAGS_EN adds out_flags = {overflow, underflow, inexact}.
module fp_norm_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [8:0]  in_exp,
    input  logic [27:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_s
`ifdef FP_NR_FLAGS_EN
    ,
    output logic [2:0]  out_flags
`endif
);
    logic        r_s1_valid, r_s1_sign, r_s2_valid;
    logic [9:0]  r_s1_exp;
    logic [26:0] r_s1_m;
    logic [31:0] r_out_s;
    logic        w_s1_adv, w_inc, w_zero, w_ovf;
    logic [4:0]  w_lz, w_sh;
    logic [8:0]  w_emax;
    logic [26:0] w_m;
    logic [9:0]  w_exp, w_ef;
    logic [24:0] w_sum;
    logic [31:0] w_s;

    assign w_s1_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_s     = r_out_s;

    // left shift is capped so the exponent never drops below 1 (denormal range)
    always_comb begin
        w_lz = 5'd27;
        for (int i = 0; i < 27; i++) if (in_mant[i]) w_lz = 5'(26 - i);
        w_emax = in_exp - 9'd1;
        w_sh   = ({4'd0, w_lz} < w_emax) ? w_lz : w_emax[4:0];
        w_m    = in_mant[27] ? {in_mant[27:2], in_mant[1] | in_mant[0]} : in_mant[26:0] << w_sh;
        w_exp  = in_mant[27] ? {1'b0, in_exp} + 10'd1 : {1'b0, in_exp} - {5'd0, w_sh};
    end

    assign w_inc  = r_s1_m[2] & (r_s1_m[1] | r_s1_m[0] | r_s1_m[3]);
    assign w_sum  = {1'b0, r_s1_m[26:3]} + 25'(w_inc);
    assign w_ef   = w_sum[24] ? r_s1_exp + 10'd1 : (w_sum[23] ? r_s1_exp : 10'd0);
    assign w_ovf  = w_ef >= 10'd255;
    assign w_zero = r_s1_m == 27'd0;
    assign w_s    = w_ovf ? {r_s1_sign, 8'hFF, 23'd0} : {r_s1_sign & !w_zero, w_ef[7:0], w_sum[22:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= 10'd0;
            r_s1_m     <= 27'd0;
            r_s2_valid <= 1'b0;
            r_out_s    <= 32'd0;
        end else begin
            if (in_ready) r_s1_valid <= in_valid;
            if (in_ready && in_valid) begin
                r_s1_sign <= in_sign;
                r_s1_exp  <= w_exp;
                r_s1_m    <= w_m;
            end
            if (w_s1_adv) r_s2_valid <= r_s1_valid;
            if (w_s1_adv && r_s1_valid) r_out_s <= w_s;
        end
    end

`ifdef FP_NR_FLAGS_EN
    logic       w_inex;
    logic [2:0] r_flags;
    assign w_inex    = (|r_s1_m[2:0]) | w_ovf;
    assign out_flags = r_flags & {3{r_s2_valid}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_flags <= 3'd0;
        else if (w_s1_adv && r_s1_valid) r_flags <= {w_ovf, (w_ef == 10'd0) & w_inex, w_inex};
    end
`endif
endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
Parameters: none.
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: in_valid  input  1  upstream adder result present.
REQ-004 SHALL: in_ready  output  1  stage can accept this cycle.
REQ-005 SHALL: in_sign  input  1  result sign.
REQ-006 SHALL: in_exp  input  9  biased exponent before normalization, legal range 1..510.
REQ-007 SHALL: in_mant  input  28  raw magnitude: [27] carry (2^1), [26] hidden (2^0), [25:3] fraction, [2] guard, [1] round, [0] sticky.
- Value = (-1)^in_sign * in_mant/2^26 * 2^(in_exp-127).
REQ-008 SHALL: out_valid  output  1  packed result present.
REQ-009 SHALL: out_ready  input  1  downstream accepts.
REQ-010 SHALL: out_s  output  32  IEEE-754 single result.

Function
REQ-011 SHALL: transfer on valid&ready at each port; 2-stage pipeline (S1 normalize, S2 round/pack); latency 2 cycles from input handshake to out_valid with no stall; throughput 1/cycle.
REQ-012 SHALL: in_ready = !S1_valid | (S1 advances this cycle); S1 advances when !S2_valid | out_ready; no bubble insertion, no data loss, order preserved.
REQ-013 SHALL: out_valid and out_s stable while out_valid & !out_ready.
REQ-014 SHALL: S1 with in_mant[27]=1 shifts right 1, ORs shifted-out bit into sticky, exp+1.
REQ-015 SHALL: S1 otherwise left-shifts by min(leading-zero count of in_mant[26:0], in_exp-1), exp reduced by the shift; hidden bit still 0 afterwards -> denormal, exponent field 0.
REQ-016 SHALL: in_mant=0 -> out_s=0x00000000 (+0) regardless of in_sign.
REQ-017 SHALL: S2 round-to-nearest-even: increment fraction when G & (R | S | fraction LSB).
REQ-018 SHALL: rounding carry out of fraction -> exp+1, fraction 0; denormal rounding into hidden bit -> exponent field 1.
REQ-019 SHALL: final exponent >= 255 -> out_s = {in_sign, 8'hFF, 23'h0}.
REQ-020 SHALL: simultaneous input and output handshakes in the same cycle both complete.

Reset
REQ-021 SHALL: rst_n low clears S1/S2 valids immediately; out_valid=0, out_s=0, in_ready=1 while reset held and on the first edge after release.
REQ-022 SHALL: reset mid-operation discards all in-flight results; none emitted after release.

Configuration
REQ-023 SHALL: macro FP_NR_FLAGS_EN defined -> extra output out_flags[2:0] = {overflow, underflow, inexact}, pipelined with and qualified by out_valid; overflow per REQ-019, underflow = tiny (denormal or zero after rounding) and inexact, inexact = any of G/R/S set after normalization; reset value 0.
REQ-024 SHALL: FP_NR_FLAGS_EN undefined -> out_flags port and its logic absent; all other behaviour identical.

Verification
REQ-025 SHALL: sign=0, exp=128, mant=0x4000000, out_ready=1 -> out_s=0x40000000 exactly 2 cycles later.
REQ-026 SHALL: exp=128, mant=0x7FFFFFF -> round-up carry -> 0x40800000; exp=127, mant=0x4000004 -> 0x3F800000 (tie, even); mant=0x400000C -> 0x3F800002.
REQ-027 SHALL: exp=127, mant=0x0000008 -> 0x34000000; mant=0 with sign=1 -> 0x00000000.
REQ-028 SHALL: exp=1, mant=0x2000000 -> 0x00400000 (denormal, underflow flag 0 since exact); exp=254, mant=0x8000000 -> 0x7F800000 with overflow=1, inexact=1 when FP_NR_FLAGS_EN.
REQ-029 SHALL: 4 back-to-back inputs with out_ready=0 -> in_ready drops after 2 accepted; out_ready=1 thereafter -> all 4 results in order, none duplicated.
REQ-030 SHALL: rst_n pulsed low while 2 results in flight -> out_valid=0 immediately; no output until new input accepted after release.
